// File: rtl/flash_access_arbiter.sv
// Round-robin owner of the shared weight/bias flash port: the network sequencer
// (read-only) and the SPI host loader (read/write) take turns, one access at a time.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's request
// ISSUE | one cycle: mem_start strobe and ack to the owner
// WAIT  | count flash read latency; capture mem_rdata on the last count
// RESP  | one cycle: response strobe to the owner, remember it for round-robin
module flash_access_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LAT_CYCLES = 11   // legal range 2..255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ack,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_start,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] LAT_TC = 8'(LAT_CYCLES);

  state_t            state_q;
  state_t            state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic [7:0]        lat_cnt_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic grant_any;
  logic grant_sel;
  logic lat_done;

  // On a tie the port that was not served last wins.
  assign grant_any = req0_valid | req1_valid;
  assign grant_sel = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign lat_done  = (lat_cnt_q == LAT_TC);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode registered state only, so request inputs never reach a port combinationally.
  always_comb begin
    state_d    = state_q;
    mem_start  = 1'b0;
    req0_ack   = 1'b0;
    req1_ack   = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (grant_any) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_start = 1'b1;
        req0_ack  = ~owner_q;
        req1_ack  = owner_q;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_done) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Flash bus registers load only on a grant and otherwise hold, keeping the bus quiet in IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      if ((state_q == ST_IDLE) && grant_any) begin
        owner_q     <= grant_sel;
        mem_write_q <= grant_sel & req1_write;
        mem_addr_q  <= grant_sel ? req1_addr : req0_addr;
        mem_wdata_q <= grant_sel ? req1_wdata : '0;
      end
      if (state_q == ST_RESP) begin
        last_grant_q <= owner_q;
      end
    end
  end

  // Counts 1..LAT_CYCLES and stops there, so it cannot wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lat_cnt_q <= 8'd0;
    end else if (state_q == ST_ISSUE) begin
      lat_cnt_q <= 8'd1;
    end else if ((state_q == ST_WAIT) && !lat_done) begin
      lat_cnt_q <= lat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_data_q <= '0;
    end else if ((state_q == ST_WAIT) && lat_done && !mem_write_q) begin
      rsp_data_q <= mem_rdata;
    end
  end

  assign rsp_data  = rsp_data_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
